// File: rtl/multiword_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer_pkg
//   Shared definitions for the multi-precision add/subtract sequencer:
//   datapath word width and the sequencer state encoding.
// ---------------------------------------------------------------------------
package multiword_add_sequencer_pkg;

  // Width of one operand word and of the shared ripple adder.
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : multiword_add_sequencer_pkg

// File: rtl/full_adder_16_bit.sv
// ---------------------------------------------------------------------------
// full_adder_16_bit
//   Purely combinational WORD_W-bit ripple-carry adder; the single shared
//   word adder of the sequencer.
//
// Ports
//   a, b : input  [WORD_W-1:0]  addend words
//   cin  : input                carry in
//   s    : output [WORD_W-1:0]  sum word
//   cout : output               carry out of the top bit
// ---------------------------------------------------------------------------
module full_adder_16_bit
  import multiword_add_sequencer_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);

  logic w_ripple;

  // NOTE: combinational logic uses blocking assignments so each bit sees the
  // carry produced by the bit below it within the same evaluation.
  always_comb begin
    w_ripple = cin;
    s        = '0;
    for (int i = 0; i < WORD_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_ripple;
      w_ripple = (a[i] & b[i]) | (w_ripple & (a[i] ^ b[i]));
    end
    cout = w_ripple;
  end

endmodule : full_adder_16_bit

// File: rtl/multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer
//   Multi-precision add/subtract engine. Operands of NUM_WORDS x 16 bits are
//   processed one word per clock, least-significant word first, through one
//   shared 16-bit ripple adder with a registered carry between words.
//   Subtraction is done as a + ~b + 1 (carry seeded with 1).
//
// Parameters
//   NUM_WORDS : words per operand (2..16); operand width W = 16*NUM_WORDS
//
// Ports
//   clk      : input          rising-edge clock
//   rst_n    : input          synchronous active-low reset
//   start    : input          operation request, only honoured in IDLE
//   sub      : input          0 = a+b, 1 = a-b (latched with operands)
//   a, b     : input  [W-1:0] operands, latched on the accepting edge
//   busy     : output         high while words are being processed
//   done     : output         one-cycle completion pulse
//   sum      : output [W-1:0] result, valid from done until next accept
//   cout     : output         add: carry out; sub: 1 = no borrow
//   overflow : output         two's-complement overflow of the W-bit op
// ---------------------------------------------------------------------------
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sub,
  input  logic [WORD_W*NUM_WORDS-1:0] a,
  input  logic [WORD_W*NUM_WORDS-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [WORD_W*NUM_WORDS-1:0] sum,
  output logic                        cout,
  output logic                        overflow
);

  localparam int W     = WORD_W * NUM_WORDS;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;       // B' : b, or ~b for subtract
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_overflow;

  logic              w_accept;
  logic              w_last;
  logic [WORD_W-1:0] w_add_a;
  logic [WORD_W-1:0] w_add_b;
  logic [WORD_W-1:0] w_add_s;
  logic              w_add_cout;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_idx == LAST_IDX);

  // Word select from the latched operands.
  assign w_add_a = r_a[r_idx*WORD_W +: WORD_W];
  assign w_add_b = r_b[r_idx*WORD_W +: WORD_W];

  full_adder_16_bit u_word_adder (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (r_carry),
    .s    (w_add_s),
    .cout (w_add_cout)
  );

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and status outputs
  // -------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand capture. Only read while RUN, which is always preceded by a
  // capture, so these registers carry no reset.
  // -------------------------------------------------------------------------
  // NOTE: leaving pure data registers out of reset keeps their enable logic
  // simple; anything observable (sum, flags, control) is reset explicitly.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= sub ? ~b : b;
    end
  end

  // -------------------------------------------------------------------------
  // Word sequencing, carry chain and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      // Carry seeded with sub turns ~b into -b for subtraction.
      r_idx   <= '0;
      r_carry <= sub;
    end else if (r_state == S_RUN) begin
      r_sum[r_idx*WORD_W +: WORD_W] <= w_add_s;
      r_carry                       <= w_add_cout;
      if (w_last) begin
        r_cout     <= w_add_cout;
        // Same-sign inputs producing a different-sign result.
        r_overflow <= (r_a[W-1] == r_b[W-1]) &&
                      (w_add_s[WORD_W-1] != r_a[W-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule : multiword_add_sequencer

// File: tb/tb_multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_sequencer
//   Directed testbench for multiword_add_sequencer with NUM_WORDS = 4.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiword_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  multiword_add_sequencer #(.NUM_WORDS(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) for done; lat counts rising edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Issue one operation from IDLE and collect its results. Inputs are
  // scrambled right after the accepting edge.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_sub, output logic [W-1:0] r_sum,
                        output logic r_cout, output logic r_ovf,
                        output int lat, output logic busy_acc,
                        output logic done_after);
    @(negedge clk);
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    @(posedge clk); #1;
    busy_acc = busy;
    start = 1'b0; a = ~op_a; b = ~op_b; sub = ~op_sub;
    wait_done(lat);
    r_sum = sum; r_cout = cout; r_ovf = overflow;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s; logic c, v, ba, da; int lat;
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, s, c, v, lat, ba, da);
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL chain_busy: got %b expected 1", ba); end
    checks++; if (lat !== NW) begin errors++; $display("FAIL chain_latency: got %0d expected %0d", lat, NW); end
    checks++; if (s !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL chain_sum: got %h expected 0000000000010000", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL chain_cout: got %b expected 0", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL chain_ovf: got %b expected 0", v); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL chain_done_width: got %b expected 0", da); end
  endtask

  task automatic test_full_wrap();
    logic [W-1:0] s; logic c, v, ba, da; int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, s, c, v, lat, ba, da);
    checks++; if (s !== 64'h0) begin errors++; $display("FAIL wrap_sum: got %h expected 0", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b expected 1", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b expected 0", v); end
  endtask

  task automatic test_subtract();
    logic [W-1:0] s; logic c, v, ba, da; int lat;
    run_op(64'h5, 64'h7, 1'b1, s, c, v, lat, ba, da);
    checks++; if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_borrow_sum: got %h expected fffffffffffffffe", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout: got %b expected 0", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL sub_borrow_ovf: got %b expected 0", v); end
    run_op(64'h7, 64'h5, 1'b1, s, c, v, lat, ba, da);
    checks++; if (s !== 64'h2) begin errors++; $display("FAIL sub_pos_sum: got %h expected 2", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_pos_cout: got %b expected 1", c); end
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL sub_pos_ovf: got %b expected 0", v); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s; logic c, v, ba, da; int lat;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, s, c, v, lat, ba, da);
    checks++; if (s !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_add_sum: got %h expected 8000000000000000", s); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_add_flag: got %b expected 1", v); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf_add_cout: got %b expected 0", c); end
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, s, c, v, lat, ba, da);
    checks++; if (s !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_sub_sum: got %h expected 7fffffffffffffff", s); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL ovf_sub_flag: got %b expected 1", v); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout: got %b expected 1", c); end
  endtask

  // Runs after test_overflow, so cout and overflow are 1 going in.
  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    a = 64'h0000_0000_0000_0001; b = 64'h2; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL midrst_sum: got %h expected 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout: got %b expected 0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h1111_1111_1111_1111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_restart_busy: got %b expected 1", busy); end
    wait_done(lat);
    checks++; if (lat !== NW) begin errors++; $display("FAIL midrst_latency: got %0d expected %0d", lat, NW); end
    checks++; if (sum !== 64'h2345_6789_ABCD_F001) begin errors++; $display("FAIL midrst_sum_after: got %h expected 23456789abcdf001", sum); end
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    int lat;
    // Part A: start pulses during RUN and DONE must be ignored, not queued.
    @(negedge clk);
    a = 64'd3; b = 64'd4; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 64'd10; b = 64'd20;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat !== NW - 1) begin errors++; $display("FAIL hs_pulse_latency: got %0d expected %0d", lat, NW - 1); end
    checks++; if (sum !== 64'd7) begin errors++; $display("FAIL hs_pulse_sum: got %0d expected 7", sum); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_done_start_ignored: busy got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_not_queued: busy got %b expected 0", busy); end
    checks++; if (sum !== 64'd7) begin errors++; $display("FAIL hs_sum_hold: got %0d expected 7", sum); end

    // Part B: start held high re-accepts only in the IDLE cycle after DONE.
    @(negedge clk);
    a = 64'd3; b = 64'd4; start = 1'b1;
    @(posedge clk); #1;
    a = 64'd10; b = 64'd20;
    wait_done(lat);
    checks++; if (lat !== NW) begin errors++; $display("FAIL hs_hold_latency1: got %0d expected %0d", lat, NW); end
    checks++; if (sum !== 64'd7) begin errors++; $display("FAIL hs_hold_sum1: got %0d expected 7", sum); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL hs_hold_idle: busy/done got %b%b expected 00", busy, done); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_hold_accept: busy got %b expected 1", busy); end
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat !== NW) begin errors++; $display("FAIL hs_hold_latency2: got %0d expected %0d", lat, NW); end
    checks++; if (sum !== 64'd30) begin errors++; $display("FAIL hs_hold_sum2: got %0d expected 30", sum); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_full_wrap();
    test_subtract();
    test_overflow();
    test_reset_mid_op();
    test_handshake();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_multiword_add_sequencer
